// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD write-cycle generator.
// Holds the write-cycle state encoding, the default 50 MHz timing values,
// and the bus-width legality check used at elaboration.
package lcd_pkg;

  // One state per phase of an LCD write cycle.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_GAP    = 3'd4,
    ST_SETTLE = 3'd5,
    ST_DONE   = 3'd6
  } lcdState_t;

  // Default timing for a 50 MHz system clock (20 ns per cycle).
  localparam int LCD_BUS_WIDTH      = 4;
  localparam int LCD_SETUP_CYC      = 2;     // 40 ns address/data setup
  localparam int LCD_PULSE_CYC      = 12;    // 240 ns E high
  localparam int LCD_HOLD_CYC       = 1;     // 20 ns data hold
  localparam int LCD_NIBBLE_GAP_CYC = 50;    // 1 us between nibbles
  localparam int LCD_CMD_GAP_CYC    = 2000;  // 40 us command settle
  localparam int LCD_CNT_W          = 16;

  // The controller only knows how to drive a 4-bit or an 8-bit data bus.
  function automatic bit lcdBusWidthOk(input int width);
    return (width == 4) || (width == 8);
  endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter that times each phase of the LCD write cycle.
// A phase loaded with N reports expiry on its N-th cycle, so the FSM can
// leave the phase on exactly that edge. The count parks at zero and never
// wraps, so an unloaded timer stays silent.
module lcd_cycle_timer
  import lcd_pkg::*;
#(
  parameter int CNT_W = LCD_CNT_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iLoad,
  input  logic [CNT_W-1:0] iLoadValue,
  output logic             oExpire
);

  logic [CNT_W-1:0] r_count;

  // Load has priority over counting; once the count reaches zero it holds
  // there until the next load so that no stray expiry can be reported.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_count <= '0;
    end else if (iLoad) begin
      r_count <= iLoadValue;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign oExpire = (r_count == CNT_W'(1));

endmodule

// File: rtl/lcd_write_strobe.sv
// HD44780-style LCD write-cycle generator. Accepts one byte plus register
// select, then drives RS, the data bus and the E strobe with programmable
// setup, pulse, hold, inter-nibble and settle timing, in either 4-bit
// (high nibble first) or 8-bit bus mode. Every output is a register fed
// from the current state, so the pins trail the state by one cycle.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int BUS_WIDTH      = LCD_BUS_WIDTH,
  parameter int SETUP_CYC      = LCD_SETUP_CYC,
  parameter int PULSE_CYC      = LCD_PULSE_CYC,
  parameter int HOLD_CYC       = LCD_HOLD_CYC,
  parameter int NIBBLE_GAP_CYC = LCD_NIBBLE_GAP_CYC,
  parameter int CMD_GAP_CYC    = LCD_CMD_GAP_CYC,
  parameter int CNT_W          = LCD_CNT_W
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic [7:0]           iData,
  input  logic                 iRS,
  output logic                 oLCD_Enabled,
  output logic                 oLCD_RS,
  output logic                 oLCD_RW,
  output logic [BUS_WIDTH-1:0] oLCD_Data,
  output logic                 oBusy,
  output logic                 oDone
);

  // Only 4-bit and 8-bit buses exist on the display; anything else is a
  // configuration mistake and must stop elaboration.
  if (!lcdBusWidthOk(BUS_WIDTH)) begin : gBadBusWidth
    $error("lcd_write_strobe: BUS_WIDTH must be 4 or 8");
  end

  lcdState_t            r_state;
  logic [7:0]           r_dataLatch;
  logic                 r_rsLatch;
  logic                 r_secondNibble;
  logic                 r_lcdEnabled;
  logic                 r_lcdRs;
  logic [BUS_WIDTH-1:0] r_lcdData;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_load;
  logic [CNT_W-1:0]     w_loadValue;
  logic                 w_expire;
  logic                 w_moreNibbles;
  logic [BUS_WIDTH-1:0] w_busValue;

  // In nibble mode the first pass through HOLD is followed by the second
  // nibble; in byte mode there is never a second pass.
  assign w_moreNibbles = (BUS_WIDTH == 4) && !r_secondNibble;

  // Pick what the data pins should carry for the current part of the write.
  if (BUS_WIDTH == 8) begin : gByteBus
    assign w_busValue = r_dataLatch;
  end else begin : gNibbleBus
    assign w_busValue = r_secondNibble ? r_dataLatch[3:0] : r_dataLatch[7:4];
  end

  lcd_cycle_timer #(
    .CNT_W(CNT_W)
  ) uTimer (
    .Clock     (Clock),
    .Reset     (Reset),
    .iLoad     (w_load),
    .iLoadValue(w_loadValue),
    .oExpire   (w_expire)
  );

  // Reload the phase timer on every state change with the length of the
  // phase being entered. SETTLE and DONE load nothing: the timer runs down
  // to zero on its own and stays quiet until the next write.
  always_comb begin
    w_load      = 1'b0;
    w_loadValue = '0;
    case (r_state)
      ST_IDLE: begin
        if (iStart) begin
          w_load      = 1'b1;
          w_loadValue = CNT_W'(SETUP_CYC);
        end
      end
      ST_SETUP: begin
        if (w_expire) begin
          w_load      = 1'b1;
          w_loadValue = CNT_W'(PULSE_CYC);
        end
      end
      ST_PULSE: begin
        if (w_expire) begin
          w_load      = 1'b1;
          w_loadValue = CNT_W'(HOLD_CYC);
        end
      end
      ST_HOLD: begin
        if (w_expire) begin
          w_load      = 1'b1;
          w_loadValue = w_moreNibbles ? CNT_W'(NIBBLE_GAP_CYC) : CNT_W'(CMD_GAP_CYC);
        end
      end
      ST_GAP: begin
        if (w_expire) begin
          w_load      = 1'b1;
          w_loadValue = CNT_W'(SETUP_CYC);
        end
      end
      default: begin
        w_load      = 1'b0;
        w_loadValue = '0;
      end
    endcase
  end

  // Write-cycle sequencer plus the output registers. A request is taken
  // only in IDLE, which makes busy-time and DONE-cycle requests vanish and
  // leaves one IDLE cycle between back-to-back writes. The byte and RS are
  // captured at acceptance so the requester may change them immediately.
  // Outputs are derived from the state held before this edge, and the bus
  // and RS keep their last value while idle so the display sees no glitch.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state        <= ST_IDLE;
      r_dataLatch    <= '0;
      r_rsLatch      <= 1'b0;
      r_secondNibble <= 1'b0;
      r_lcdEnabled   <= 1'b0;
      r_lcdRs        <= 1'b0;
      r_lcdData      <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            r_dataLatch    <= iData;
            r_rsLatch      <= iRS;
            r_secondNibble <= 1'b0;
            r_state        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_expire) r_state <= ST_PULSE;
        end
        ST_PULSE: begin
          if (w_expire) r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (w_expire) begin
            if (w_moreNibbles) begin
              r_state <= ST_GAP;
            end else if (CMD_GAP_CYC == 0) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_SETTLE;
            end
          end
        end
        ST_GAP: begin
          if (w_expire) begin
            r_secondNibble <= 1'b1;
            r_state        <= ST_SETUP;
          end
        end
        ST_SETTLE: begin
          if (w_expire) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      r_lcdEnabled <= (r_state == ST_PULSE);
      r_busy       <= (r_state != ST_IDLE);
      r_done       <= (r_state == ST_DONE);
      if (r_state != ST_IDLE) begin
        r_lcdRs   <= r_rsLatch;
        r_lcdData <= w_busValue;
      end
    end
  end

  assign oLCD_Enabled = r_lcdEnabled;
  assign oLCD_RS      = r_lcdRs;
  assign oLCD_RW      = 1'b0;
  assign oLCD_Data    = r_lcdData;
  assign oBusy        = r_busy;
  assign oDone        = r_done;

endmodule

// File: tb/tb_lcd_write_strobe.sv
// Directed bench for lcd_write_strobe. Three instances share the inputs:
// an 8-bit bus with a short settle, a 4-bit bus with a short nibble gap,
// and an 8-bit bus with no settle at all. Cycle numbers below count edges
// after the acceptance edge, sampled 1 ns after each rising edge.
module tb_lcd_write_strobe;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iStart = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       iRS = 1'b0;

  logic       e8, rs8, rw8, busy8, done8;
  logic [7:0] d8;
  logic       e4, rs4, rw4, busy4, done4;
  logic [3:0] d4;
  logic       e0, rs0, rw0, busy0, done0;
  logic [7:0] d0;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  lcd_write_strobe #(
    .BUS_WIDTH(8), .SETUP_CYC(2), .PULSE_CYC(12), .HOLD_CYC(1),
    .NIBBLE_GAP_CYC(5), .CMD_GAP_CYC(10), .CNT_W(16)
  ) dut8 (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iData(iData), .iRS(iRS),
    .oLCD_Enabled(e8), .oLCD_RS(rs8), .oLCD_RW(rw8), .oLCD_Data(d8),
    .oBusy(busy8), .oDone(done8)
  );

  lcd_write_strobe #(
    .BUS_WIDTH(4), .SETUP_CYC(2), .PULSE_CYC(12), .HOLD_CYC(1),
    .NIBBLE_GAP_CYC(5), .CMD_GAP_CYC(10), .CNT_W(16)
  ) dut4 (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iData(iData), .iRS(iRS),
    .oLCD_Enabled(e4), .oLCD_RS(rs4), .oLCD_RW(rw4), .oLCD_Data(d4),
    .oBusy(busy4), .oDone(done4)
  );

  lcd_write_strobe #(
    .BUS_WIDTH(8), .SETUP_CYC(2), .PULSE_CYC(12), .HOLD_CYC(1),
    .NIBBLE_GAP_CYC(5), .CMD_GAP_CYC(0), .CNT_W(16)
  ) dut0 (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iData(iData), .iRS(iRS),
    .oLCD_Enabled(e0), .oLCD_RS(rs0), .oLCD_RW(rw0), .oLCD_Data(d0),
    .oBusy(busy0), .oDone(done0)
  );

  // Present a write request for one edge (or leave it held), ending 1 ns
  // after the acceptance edge, which is cycle 0.
  task automatic applyStimulus(input logic [7:0] data, input logic rs, input logic hold);
    iData  = data;
    iRS    = rs;
    iStart = 1'b1;
    @(posedge Clock); #1;
    if (!hold) iStart = 1'b0;
  endtask

  // Let every instance drain back to idle, bounded so a stuck design fails.
  task automatic waitIdle(input string name);
    int waited;
    waited = 0;
    while ((busy8 !== 1'b0 || busy4 !== 1'b0 || busy0 !== 1'b0) && waited < 300) begin
      @(posedge Clock); #1;
      waited++;
    end
    checks++;
    if (waited >= 300) begin
      failures++;
      $display("[TB] FAIL %s_idle: busy8=%b busy4=%b busy0=%b still high after 300 cycles", name, busy8, busy4, busy0);
    end
    repeat (2) @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    checks++;
    if ({e8, rs8, rw8, d8, busy8, done8} !== 13'h0) begin
      failures++;
      $display("[TB] FAIL reset_dut8: got E=%b RS=%b RW=%b D=%h busy=%b done=%b, want all 0", e8, rs8, rw8, d8, busy8, done8);
    end
    checks++;
    if ({e4, rs4, rw4, d4, busy4, done4} !== 9'h0) begin
      failures++;
      $display("[TB] FAIL reset_dut4: got E=%b RS=%b RW=%b D=%h busy=%b done=%b, want all 0", e4, rs4, rw4, d4, busy4, done4);
    end
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_8bit_write();
    int firstE = -1, lastE = -1, eCount = 0, doneCycle = -1, doneCount = 0, badData = 0, badRs = 0;
    logic busy0c, busy1c, busy26c, busy27c;
    busy0c = busy8;
    applyStimulus(8'h38, 1'b0, 1'b0);
    busy0c = busy8;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge Clock); #1;
      if (e8 === 1'b1) begin
        if (firstE < 0) firstE = cyc;
        lastE = cyc;
        eCount++;
      end
      if (done8 === 1'b1) begin
        if (doneCycle < 0) doneCycle = cyc;
        doneCount++;
      end
      if (cyc <= 26 && d8 !== 8'h38) badData++;
      if (rs8 !== 1'b0 || rw8 !== 1'b0) badRs++;
      if (cyc == 1) busy1c = busy8;
      if (cyc == 26) busy26c = busy8;
      if (cyc == 27) busy27c = busy8;
    end
    checks++; if (busy0c !== 1'b0) begin failures++; $display("[TB] FAIL w8_busy_c0: got %b want 0", busy0c); end
    checks++; if (busy1c !== 1'b1) begin failures++; $display("[TB] FAIL w8_busy_c1: got %b want 1", busy1c); end
    checks++; if (firstE !== 3) begin failures++; $display("[TB] FAIL w8_e_rise: got %0d want 3", firstE); end
    checks++; if (lastE !== 14) begin failures++; $display("[TB] FAIL w8_e_last: got %0d want 14", lastE); end
    checks++; if (eCount !== 12) begin failures++; $display("[TB] FAIL w8_e_len: got %0d want 12", eCount); end
    checks++; if (badData !== 0) begin failures++; $display("[TB] FAIL w8_data: got %0d cycles off 0x38 want 0", badData); end
    checks++; if (badRs !== 0) begin failures++; $display("[TB] FAIL w8_rs_rw: got %0d cycles with RS/RW high want 0", badRs); end
    checks++; if (doneCycle !== 26) begin failures++; $display("[TB] FAIL w8_done_cycle: got %0d want 26", doneCycle); end
    checks++; if (doneCount !== 1) begin failures++; $display("[TB] FAIL w8_done_count: got %0d want 1", doneCount); end
    checks++; if (busy26c !== 1'b1) begin failures++; $display("[TB] FAIL w8_busy_c26: got %b want 1", busy26c); end
    checks++; if (busy27c !== 1'b0) begin failures++; $display("[TB] FAIL w8_busy_c27: got %b want 0", busy27c); end
    waitIdle("w8");
  endtask

  task automatic test_4bit_write();
    int rises = 0, fallCycle = -1, doneCycle = -1, badRs = 0, badNib = 0;
    int riseAt[4];
    int lenOf[4];
    logic prevE;
    riseAt = '{-1, -1, -1, -1};
    lenOf  = '{0, 0, 0, 0};
    applyStimulus(8'hA5, 1'b1, 1'b0);
    prevE = e4;
    for (int cyc = 1; cyc <= 55; cyc++) begin
      @(posedge Clock); #1;
      if (e4 === 1'b1 && prevE !== 1'b1 && rises < 4) begin
        riseAt[rises] = cyc;
        rises++;
      end
      if (e4 === 1'b1 && rises > 0) lenOf[rises-1]++;
      if (e4 !== 1'b1 && prevE === 1'b1 && fallCycle < 0) fallCycle = cyc;
      if (e4 === 1'b1 && rises == 1 && d4 !== 4'hA) badNib++;
      if (e4 === 1'b1 && rises == 2 && d4 !== 4'h5) badNib++;
      if (done4 === 1'b1 && doneCycle < 0) doneCycle = cyc;
      if (cyc <= 46 && rs4 !== 1'b1) badRs++;
      prevE = e4;
    end
    checks++; if (rises !== 2) begin failures++; $display("[TB] FAIL w4_pulses: got %0d want 2", rises); end
    checks++; if (riseAt[0] !== 3) begin failures++; $display("[TB] FAIL w4_rise1: got %0d want 3", riseAt[0]); end
    checks++; if (lenOf[0] !== 12 || lenOf[1] !== 12) begin failures++; $display("[TB] FAIL w4_len: got %0d/%0d want 12/12", lenOf[0], lenOf[1]); end
    checks++; if (riseAt[1] - fallCycle !== 8) begin failures++; $display("[TB] FAIL w4_low_gap: got %0d want 8", riseAt[1] - fallCycle); end
    checks++; if (badNib !== 0) begin failures++; $display("[TB] FAIL w4_nibbles: got %0d pulse cycles with wrong nibble want 0", badNib); end
    checks++; if (badRs !== 0) begin failures++; $display("[TB] FAIL w4_rs: got %0d cycles with RS low want 0", badRs); end
    checks++; if (doneCycle !== 46) begin failures++; $display("[TB] FAIL w4_done_cycle: got %0d want 46", doneCycle); end
    waitIdle("w4");
  endtask

  task automatic test_busy_reject();
    int doneCount = 0, doneCycle = -1, eRises = 0, sawFF = 0;
    logic prevE, busy40c;
    applyStimulus(8'h38, 1'b0, 1'b0);
    prevE = e8;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge Clock); #1;
      if (cyc == 8) begin iStart = 1'b1; iData = 8'hFF; end
      if (cyc == 9) iStart = 1'b0;
      if (e8 === 1'b1 && prevE !== 1'b1) eRises++;
      if (d8 === 8'hFF) sawFF++;
      if (done8 === 1'b1) begin
        if (doneCycle < 0) doneCycle = cyc;
        doneCount++;
      end
      if (cyc == 40) busy40c = busy8;
      prevE = e8;
    end
    checks++; if (sawFF !== 0) begin failures++; $display("[TB] FAIL busy_bus: got %0d cycles of 0xFF want 0", sawFF); end
    checks++; if (eRises !== 1) begin failures++; $display("[TB] FAIL busy_pulses: got %0d want 1", eRises); end
    checks++; if (doneCount !== 1) begin failures++; $display("[TB] FAIL busy_done_count: got %0d want 1", doneCount); end
    checks++; if (doneCycle !== 26) begin failures++; $display("[TB] FAIL busy_done_cycle: got %0d want 26", doneCycle); end
    checks++; if (busy40c !== 1'b0) begin failures++; $display("[TB] FAIL busy_not_queued: got %b want 0", busy40c); end
    waitIdle("busy");
  endtask

  task automatic test_reset_mid_write();
    int doneCount = 0, doneCycle = -1;
    applyStimulus(8'hA5, 1'b1, 1'b0);
    for (int cyc = 1; cyc <= 28; cyc++) begin
      @(posedge Clock); #1;
      if (done4 === 1'b1) doneCount++;
    end
    checks++; if (e4 !== 1'b1 || d4 !== 4'h5) begin failures++; $display("[TB] FAIL rst_pre: got E=%b D=%h want E=1 D=5", e4, d4); end
    Reset = 1'b1;
    @(posedge Clock); #1;
    checks++;
    if (e4 !== 1'b0 || d4 !== 4'h0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_mid: got E=%b D=%h busy=%b done=%b want 0/0/0/0", e4, d4, busy4, done4);
    end
    Reset = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge Clock); #1;
      if (done4 === 1'b1) doneCount++;
    end
    checks++; if (doneCount !== 0) begin failures++; $display("[TB] FAIL rst_no_done: got %0d pulses want 0", doneCount); end
    applyStimulus(8'hA5, 1'b1, 1'b0);
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(posedge Clock); #1;
      if (done4 === 1'b1 && doneCycle < 0) doneCycle = cyc;
    end
    checks++; if (doneCycle !== 46) begin failures++; $display("[TB] FAIL rst_fresh_done: got %0d want 46", doneCycle); end
    waitIdle("rst");
  endtask

  task automatic test_back_to_back();
    int done1 = -1, done2 = -1;
    logic busy17c, busy18c;
    applyStimulus(8'h06, 1'b0, 1'b1);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge Clock); #1;
      if (cyc == 30) iStart = 1'b0;
      if (done0 === 1'b1) begin
        if (done1 < 0) done1 = cyc;
        else if (done2 < 0) done2 = cyc;
      end
      if (cyc == 17) busy17c = busy0;
      if (cyc == 18) busy18c = busy0;
    end
    checks++; if (done1 !== 16) begin failures++; $display("[TB] FAIL b2b_done1: got %0d want 16", done1); end
    checks++; if (busy17c !== 1'b0) begin failures++; $display("[TB] FAIL b2b_gap_busy: got %b want 0", busy17c); end
    checks++; if (busy18c !== 1'b1) begin failures++; $display("[TB] FAIL b2b_reaccept: got %b want 1", busy18c); end
    checks++; if (done2 !== 33) begin failures++; $display("[TB] FAIL b2b_done2: got %0d want 33", done2); end
    waitIdle("b2b");
  endtask

  task automatic test_data_change();
    int badData = 0, eCount = 0;
    applyStimulus(8'h38, 1'b0, 1'b0);
    iData = 8'h01;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge Clock); #1;
      if (cyc <= 26 && d8 !== 8'h38) badData++;
      if (e8 === 1'b1) eCount++;
    end
    checks++; if (badData !== 0) begin failures++; $display("[TB] FAIL chg_data: got %0d cycles off 0x38 want 0", badData); end
    checks++; if (eCount !== 12) begin failures++; $display("[TB] FAIL chg_e_len: got %0d want 12", eCount); end
    waitIdle("chg");
  endtask

  initial begin
    test_reset();
    test_8bit_write();
    test_4bit_write();
    test_busy_reject();
    test_reset_mid_write();
    test_back_to_back();
    test_data_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
